reg_write_scoreboard: RTL and testbench

//  Tracks in-flight register writes between ID issue and WB retire: the producer side of hazard checking.
//  Per-register counters mark a destination pending when issued and clear it when written back.

---
 rtl/reg_write_scoreboard_if.sv | 30 +++
 rtl/reg_write_scoreboard.sv | 67 ++++++
 tb/tb_reg_write_scoreboard.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_write_scoreboard_if.sv
// reg_write_scoreboard_if: issue/retire/status bundle between the ID/WB stages and the write scoreboard.
//   master: ID/WB side; drives the issue and retire fields, observes hazard and status.
//   slave : scoreboard side; observes issue and retire, drives hazard and status.
interface reg_write_scoreboard_if #(
    parameter int REG_NUM = 16,
    parameter int ADDR_W  = 4,
    parameter int STALL_W = 16
);
    logic               Issue_Valid;
    logic               Issue_WB_EN;
    logic [ADDR_W-1:0]  Issue_Dest;
    logic [ADDR_W-1:0]  Src1;
    logic [ADDR_W-1:0]  Src2;
    logic               Two_Src;
    logic               Retire_WB_EN;
    logic [ADDR_W-1:0]  Retire_Dest;
    logic               Hazard_Detected;
    logic               Issue_Accept;
    logic [REG_NUM-1:0] Pending;
    logic [STALL_W-1:0] Stall_Count;
    logic               Underflow_Err;
    modport master (
        output Issue_Valid, Issue_WB_EN, Issue_Dest, Src1, Src2, Two_Src, Retire_WB_EN, Retire_Dest,
        input  Hazard_Detected, Issue_Accept, Pending, Stall_Count, Underflow_Err
    );
    modport slave (
        input  Issue_Valid, Issue_WB_EN, Issue_Dest, Src1, Src2, Two_Src, Retire_WB_EN, Retire_Dest,
        output Hazard_Detected, Issue_Accept, Pending, Stall_Count, Underflow_Err
    );
endinterface

// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: per-register in-flight write counters that stall ID on pending source registers.
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_write_scoreboard_if.slave (issue, sources, retire in; hazard, accept, pending, stall count, underflow out)
//   Optional macro SCOREBOARD_WB_BYPASS_EN: a same-cycle retire releases the last pending write of a source
//   and reduces the destination count for the full check (register file must write through).
module reg_write_scoreboard #(
    parameter int REG_NUM = 16,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    reg_write_scoreboard_if.slave bus
);
    logic [REG_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [STALL_W-1:0]            stall_q, stall_d;
    logic                          uf_q, uf_d;
    logic                          src1_hit, src2_hit, full, hazard, accept;
    logic [CNT_W-1:0]              dest_cnt;
    logic [REG_NUM-1:0]            pending;

    always_comb begin
        src1_hit = cnt_q[bus.Src1] != '0;
        src2_hit = bus.Two_Src && cnt_q[bus.Src2] != '0;
        dest_cnt = cnt_q[bus.Issue_Dest];
`ifdef SCOREBOARD_WB_BYPASS_EN
        // The retiring write is the only one outstanding, so the operand comes from the write-through path.
        src1_hit = src1_hit && !(bus.Retire_WB_EN && bus.Retire_Dest == bus.Src1 && cnt_q[bus.Src1] == CNT_W'(1));
        src2_hit = src2_hit && !(bus.Retire_WB_EN && bus.Retire_Dest == bus.Src2 && cnt_q[bus.Src2] == CNT_W'(1));
        dest_cnt = (bus.Retire_WB_EN && bus.Retire_Dest == bus.Issue_Dest && dest_cnt != '0) ? dest_cnt - CNT_W'(1) : dest_cnt;
`endif
        full   = bus.Issue_WB_EN && (&dest_cnt);
        hazard = bus.Issue_Valid && (src1_hit || src2_hit || full);
        accept = bus.Issue_Valid && !hazard;
    end

    // Decrement is suppressed on a zero count so counters never wrap down; full blocks issue so they never wrap up.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            cnt_d[i] = cnt_q[i]
                     + CNT_W'(accept && bus.Issue_WB_EN && bus.Issue_Dest == ADDR_W'(i))
                     - CNT_W'(bus.Retire_WB_EN && bus.Retire_Dest == ADDR_W'(i) && cnt_q[i] != '0);
            pending[i] = |cnt_q[i];
        end
        uf_d    = uf_q || (bus.Retire_WB_EN && cnt_q[bus.Retire_Dest] == '0);
        stall_d = (hazard && !(&stall_q)) ? stall_q + STALL_W'(1) : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            stall_q <= '0;
            uf_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            uf_q    <= uf_d;
        end
    end

    assign bus.Hazard_Detected = hazard;
    assign bus.Issue_Accept    = accept;
    assign bus.Pending         = pending;
    assign bus.Stall_Count     = stall_q;
    assign bus.Underflow_Err   = uf_q;
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb_reg_write_scoreboard: directed vectors with a queue-based scoreboard checked by a separate monitor.
module tb_reg_write_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [15:0] S0 = BYP ? 16'd1 : 16'd2;
    localparam logic [15:0] S1 = S0 + 16'd1;

    typedef struct {
        string       name;
        logic        h;
        logic        a;
        logic [15:0] p;
        logic [15:0] s;
        logic        u;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_write_scoreboard_if bus ();
    reg_write_scoreboard dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic drive(input logic iv, input logic wb, input logic [3:0] dest, input logic [3:0] s1,
                         input logic [3:0] s2, input logic two, input logic rwb, input logic [3:0] rd,
                         input logic eh, input logic ea, input logic [15:0] ep, input logic [15:0] es,
                         input logic eu, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus.Issue_Valid  = iv;
        bus.Issue_WB_EN  = wb;
        bus.Issue_Dest   = dest;
        bus.Src1         = s1;
        bus.Src2         = s2;
        bus.Two_Src      = two;
        bus.Retire_WB_EN = rwb;
        bus.Retire_Dest  = rd;
        e.name = name;
        e.h = eh;
        e.a = ea;
        e.p = ep;
        e.s = es;
        e.u = eu;
        q.push_back(e);
    endtask

    task automatic check(input string name, input string field, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s got %0h expected %0h", name, field, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check(e.name, "hazard", 16'(bus.Hazard_Detected), 16'(e.h));
                check(e.name, "accept", 16'(bus.Issue_Accept), 16'(e.a));
                check(e.name, "pending", bus.Pending, e.p);
                check(e.name, "stall", bus.Stall_Count, e.s);
                check(e.name, "underflow", 16'(bus.Underflow_Err), 16'(e.u));
            end
        end
    end

    initial begin
        bus.Issue_Valid  = 1'b0;
        bus.Issue_WB_EN  = 1'b0;
        bus.Issue_Dest   = '0;
        bus.Src1         = '0;
        bus.Src2         = '0;
        bus.Two_Src      = 1'b0;
        bus.Retire_WB_EN = 1'b0;
        bus.Retire_Dest  = '0;
        drive(0,0,0,0,0,0,0,0, 0,0,16'h0000,16'd0,0, "reset");
        rst = 1'b0;
        drive(1,0,0,0,0,0,0,0, 0,1,16'h0000,16'd0,0, "idle_accept");
        drive(1,1,3,0,0,0,0,0, 0,1,16'h0000,16'd0,0, "issue_r3");
        drive(1,0,0,3,0,0,0,0, 1,0,16'h0008,16'd0,0, "raw_r3_stall");
        drive(1,0,0,3,0,0,1,3, !BYP,BYP,16'h0008,16'd1,0, "raw_r3_retire_cycle");
        drive(1,0,0,3,0,0,0,0, 0,1,16'h0000,S0,0, "raw_r3_after_retire");
        drive(1,1,5,0,0,0,0,0, 0,1,16'h0000,S0,0, "issue_r5_1");
        drive(1,1,5,0,0,0,0,0, 0,1,16'h0020,S0,0, "issue_r5_2");
        drive(1,1,5,0,0,0,0,0, 0,1,16'h0020,S0,0, "issue_r5_3");
        drive(1,1,5,0,0,0,0,0, 1,0,16'h0020,S0,0, "issue_r5_full");
        drive(0,0,0,0,0,0,1,5, 0,0,16'h0020,S1,0, "retire_r5");
        drive(1,1,5,0,0,0,0,0, 0,1,16'h0020,S1,0, "issue_r5_after_retire");
        drive(1,1,7,0,0,0,0,0, 0,1,16'h0020,S1,0, "issue_r7");
        drive(1,1,7,0,0,0,1,7, 0,1,16'h00A0,S1,0, "issue_retire_r7");
        drive(0,0,0,0,0,0,0,0, 0,0,16'h00A0,S1,0, "r7_net_zero");
        drive(0,0,0,0,0,0,1,9, 0,0,16'h00A0,S1,0, "retire_r9_empty");
        drive(0,0,0,0,0,0,0,0, 0,0,16'h00A0,S1,1, "underflow_set");
        drive(0,0,0,0,0,0,0,0, 0,0,16'h00A0,S1,1, "underflow_sticky");
        drive(1,1,2,0,0,0,0,0, 0,1,16'h00A0,S1,1, "issue_r2");
        drive(1,0,0,0,2,0,0,0, 0,1,16'h00A4,S1,1, "src2_ignored");
        drive(1,0,0,0,2,1,0,0, 1,0,16'h00A4,S1,1, "src2_hazard_1");
        drive(1,0,0,0,2,1,0,0, 1,0,16'h00A4,S1+16'd1,1, "src2_hazard_2");
        drive(1,0,0,0,2,1,0,0, 1,0,16'h00A4,S1+16'd2,1, "src2_hazard_3");
        drive(0,0,0,0,0,0,0,0, 0,0,16'h00A4,S1+16'd3,1, "stall_count_final");
        rst = 1'b1;
        drive(0,0,0,0,0,0,0,0, 0,0,16'h0000,16'd0,0, "mid_reset");
        rst = 1'b0;
        drive(1,0,0,5,2,1,0,0, 0,1,16'h0000,16'd0,0, "post_reset_clear");
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending_vectors got %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
